// File: rtl/pulse_capture_ctrl.sv
// Velocimeter front end: samples the wheel-sensor line into a 1-bit sample RAM
// at a fixed tick rate, then scans the RAM back and counts rising edges.
module pulse_capture_ctrl #(
    parameter int DEPTH      = 30000,
    parameter int AW         = 15,
    parameter int SAMPLE_DIV = 1000,
    parameter int CW         = 15
) (
    input  logic          clka,
    input  logic          rst,
    input  logic          start,
    input  logic          sensor_in,
    output logic          wea,
    output logic [AW-1:0] addra,
    output logic          dina,
    input  logic          douta,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] edge_count
);

    localparam int            TW        = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_DIV - 1);
    localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CAPTURE = 2'd1;
    localparam logic [1:0] ST_SCAN    = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    logic [1:0]    state;
    logic          s1;
    logic          s2;
    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic [AW-1:0] wr_addr;
    logic          wr_last;    // final write has been issued onto the RAM port
    logic          rd_valid;   // douta carries data for an address presented last cycle
    logic          rd_last;    // douta carries the bit for address DEPTH-1
    logic          first_bit;  // next consumed bit is address 0 (seeds prev only)
    logic          prev_bit;
    logic [CW-1:0] count;
    logic          rise;

    // Two-flop synchronizer for the asynchronous sensor line, active in every state
    always_ff @(posedge clka) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= sensor_in;
            s2 <= s1;
        end
    end

    // Sample tick, rising-edge detect on returned RAM data, and busy flag
    always_comb begin
        tick = (tick_cnt == TICK_LAST);
        rise = rd_valid && !first_bit && !prev_bit && douta;
        busy = (state == ST_CAPTURE) || (state == ST_SCAN);
    end

    // Capture/scan sequencer with registered RAM port outputs
    always_ff @(posedge clka) begin
        if (rst) begin
            state      <= ST_IDLE;
            wea        <= 1'b0;
            addra      <= '0;
            dina       <= 1'b0;
            done       <= 1'b0;
            edge_count <= '0;
            tick_cnt   <= '0;
            wr_addr    <= '0;
            wr_last    <= 1'b0;
            rd_valid   <= 1'b0;
            rd_last    <= 1'b0;
            first_bit  <= 1'b1;
            prev_bit   <= 1'b0;
            count      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    wea   <= 1'b0;
                    addra <= '0;
                    if (start) begin
                        state    <= ST_CAPTURE;
                        wr_addr  <= '0;
                        tick_cnt <= '0;
                        wr_last  <= 1'b0;
                    end
                end
                ST_CAPTURE: begin
                    tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
                    // Writes are registered, so the last write is on the port one
                    // cycle after it is issued; leave CAPTURE only after that cycle.
                    if (wr_last) begin
                        wea       <= 1'b0;
                        addra     <= '0;
                        state     <= ST_SCAN;
                        rd_valid  <= 1'b0;
                        rd_last   <= 1'b0;
                        first_bit <= 1'b1;
                        count     <= '0;
                    end else if (tick) begin
                        wea   <= 1'b1;
                        addra <= wr_addr;
                        dina  <= s2;
                        if (wr_addr == ADDR_LAST) begin
                            wr_last <= 1'b1;
                        end else begin
                            wr_addr <= wr_addr + AW'(1);
                        end
                    end else begin
                        wea <= 1'b0;
                    end
                end
                ST_SCAN: begin
                    wea      <= 1'b0;
                    rd_valid <= 1'b1;
                    if (addra == ADDR_LAST) begin
                        rd_last <= 1'b1;
                    end else begin
                        addra <= addra + AW'(1);
                    end
                    if (rd_valid) begin
                        first_bit <= 1'b0;
                        prev_bit  <= douta;
                        if (rise) begin
                            count <= count + CW'(1);
                        end
                    end
                    if (rd_last) begin
                        state      <= ST_DONE;
                        edge_count <= count + CW'(rise);
                        done       <= 1'b1;
                        addra      <= '0;
                    end
                end
                ST_DONE: begin
                    wea   <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_capture_ctrl.sv
// Bench for pulse_capture_ctrl: two instances (full-rate and divided sampling),
// behavioural RAMs, a cycle-indexed reference model and directed scenarios.
module tb_pulse_capture_ctrl;

    localparam int AW = 15;
    localparam int CW = 15;
    localparam int DA = 16;
    localparam int SA = 1;
    localparam int DB = 8;
    localparam int SB = 4;
    localparam int HN = 8192;

    logic clka = 1'b0;
    logic rst = 1'b1;
    logic start_a = 1'b0;
    logic start_b = 1'b0;
    logic sensor_in = 1'b0;

    logic          wea_a, dina_a, douta_a, busy_a, done_a;
    logic [AW-1:0] addra_a;
    logic [CW-1:0] edge_count_a;
    logic          wea_b, dina_b, douta_b, busy_b, done_b;
    logic [AW-1:0] addra_b;
    logic [CW-1:0] edge_count_b;

    int n_checks = 0;
    int n_fail = 0;
    int n_wea_a = 0, n_done_a = 0, n_wea_b = 0, n_busy_b = 0;

    // clock
    always #5 clka = ~clka;

    pulse_capture_ctrl #(.DEPTH(DA), .AW(AW), .SAMPLE_DIV(SA), .CW(CW)) u_a (
        .clka(clka), .rst(rst), .start(start_a), .sensor_in(sensor_in),
        .wea(wea_a), .addra(addra_a), .dina(dina_a), .douta(douta_a),
        .busy(busy_a), .done(done_a), .edge_count(edge_count_a)
    );

    pulse_capture_ctrl #(.DEPTH(DB), .AW(AW), .SAMPLE_DIV(SB), .CW(CW)) u_b (
        .clka(clka), .rst(rst), .start(start_b), .sensor_in(sensor_in),
        .wea(wea_b), .addra(addra_b), .dina(dina_b), .douta(douta_b),
        .busy(busy_b), .done(done_b), .edge_count(edge_count_b)
    );

    logic ram_a [0:DA-1];
    logic ram_b [0:DB-1];

    // registered-output 1-bit RAMs
    always @(posedge clka) begin
        if (wea_a) ram_a[addra_a[3:0]] <= dina_a;
        douta_a <= ram_a[addra_a[3:0]];
        if (wea_b) ram_b[addra_b[2:0]] <= dina_b;
        douta_b <= ram_b[addra_b[2:0]];
    end

    // ---------------- reference model ----------------
    int   cyc = 0;          // index of the next rising edge
    logic hist [0:HN-1];    // sensor_in as seen at each rising edge
    bit   vld = 1'b0;
    bit   act_a = 1'b0, act_b = 1'b0;
    int   ns_a = 0, ns_b = 0;
    logic [CW-1:0] mec_a = '0, mec_b = '0;

    function automatic int kdone(input int d, input int sd);
        return d * sd + d + 2;
    endfunction

    // sample stored at RAM address j: sensor two flops back at the j-th tick edge
    function automatic logic sample_bit(input int sd, input int ns, input int j);
        return hist[ns + sd * (j + 1) - 2];
    endfunction

    function automatic int model_count(input int d, input int sd, input int ns);
        int   n;
        logic p, b;
        n = 0;
        p = 1'b0;
        for (int j = 0; j < d; j++) begin
            b = sample_bit(sd, ns, j);
            if (j > 0 && !p && b) n++;
            p = b;
        end
        return n;
    endfunction

    // model state advance on every rising edge
    always @(posedge clka) begin
        if (cyc < HN) hist[cyc] <= sensor_in;
        cyc <= cyc + 1;
        if (rst) begin
            vld   <= 1'b1;
            act_a <= 1'b0;
            act_b <= 1'b0;
            mec_a <= '0;
            mec_b <= '0;
        end else begin
            if (!act_a) begin
                if (start_a) begin act_a <= 1'b1; ns_a <= cyc; end
            end else if (cyc - ns_a == kdone(DA, SA)) begin
                mec_a <= CW'(model_count(DA, SA, ns_a));
            end else if (cyc - ns_a - 1 == kdone(DA, SA)) begin
                act_a <= 1'b0;
            end
            if (!act_b) begin
                if (start_b) begin act_b <= 1'b1; ns_b <= cyc; end
            end else if (cyc - ns_b == kdone(DB, SB)) begin
                mec_b <= CW'(model_count(DB, SB, ns_b));
            end else if (cyc - ns_b - 1 == kdone(DB, SB)) begin
                act_b <= 1'b0;
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic check_dut(input string nm, input int d, input int sd, input bit act,
                             input int ns, input logic [CW-1:0] mec, input logic wea,
                             input logic [AW-1:0] addra, input logic dina, input logic busy,
                             input logic done, input logic [CW-1:0] ec);
        int   k, ea;
        logic ew, eb, ed;
        bit   chk_a;
        k = 0; ea = 0; ew = 1'b0; eb = 1'b0; ed = 1'b0; chk_a = 1'b1;
        if (act) begin
            k = cyc - ns - 1;
            if (k <= d * sd) begin
                eb = 1'b1;
                ew = (k >= sd) && (k % sd == 0);
                ea = (k < sd) ? 0 : k / sd - 1;
            end else if (k <= d * sd + d + 1) begin
                eb = 1'b1;
                ea = k - (d * sd + 1);
                if (ea > d - 1) ea = d - 1;
            end else begin
                ed = 1'b1;
                chk_a = 1'b0;
            end
        end
        check($sformatf("%s_wea", nm), wea, ew);
        check($sformatf("%s_busy", nm), busy, eb);
        check($sformatf("%s_done", nm), done, ed);
        check($sformatf("%s_edge_count", nm), ec, mec);
        if (chk_a) check($sformatf("%s_addra", nm), addra, ea);
        if (ew) check($sformatf("%s_dina", nm), dina, sample_bit(sd, ns, k / sd - 1));
    endtask

    // every-cycle comparison against the model, plus event counters
    always @(negedge clka) begin
        if (vld) begin
            check_dut("a", DA, SA, act_a, ns_a, mec_a, wea_a, addra_a, dina_a, busy_a, done_a, edge_count_a);
            check_dut("b", DB, SB, act_b, ns_b, mec_b, wea_b, addra_b, dina_b, busy_b, done_b, edge_count_b);
        end
        if (wea_a === 1'b1) n_wea_a++;
        if (done_a === 1'b1) n_done_a++;
        if (wea_b === 1'b1) n_wea_b++;
        if (busy_b === 1'b1) n_busy_b++;
    end

    // ---------------- stimulus ----------------
    int mode = 0;   // 0: low, 1: high, 2: square wave
    int base = 0;
    int half = 2;

    // sensor pattern driver; value set here is sampled at edge index cyc
    always @(negedge clka) begin
        if (mode == 0) sensor_in = 1'b0;
        else if (mode == 1) sensor_in = 1'b1;
        else sensor_in = (cyc >= base) ? (((cyc - base) / half) % 2 == 1) : 1'b0;
    end

    // arrange the sensor pattern, then issue start so it is sampled at edge ns
    task automatic launch(input bit which_b, input int m, input int hf, output int ns);
        @(negedge clka);
        ns   = cyc + 4;
        base = ns - 1;
        half = hf;
        mode = m;
        repeat (4) @(negedge clka);
        if (which_b) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clka);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_done(input bit which_b, input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clka);
            if ((which_b ? done_b : done_a) === 1'b1) begin
                at = cyc;
                break;
            end
        end
        n_checks++;
        if (at < 0) begin
            n_fail++;
            $display("FAIL done_timeout: no done within %0d cycles", limit);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int ns, at, w0, d0, b0;
        rst = 1'b1;
        repeat (3) @(negedge clka);
        rst = 1'b0;
        @(negedge clka);
        check("rst_wea", wea_a, 0);
        check("rst_addra", addra_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_edge_count", edge_count_a, 0);

        // square wave 0011... with a start pulse issued during SCAN
        d0 = n_done_a;
        launch(1'b0, 2, 2, ns);
        repeat (21) @(negedge clka);
        check("a_busy_in_scan", busy_a, 1);
        start_a = 1'b1;
        @(negedge clka);
        start_a = 1'b0;
        wait_done(1'b0, 60, at);
        check("a_square_edge_count", edge_count_a, 4);
        check("a_done_latency_in_window", (at - ns >= 32) && (at - ns <= 36), 1);
        repeat (40) @(negedge clka);
        check("a_single_done", n_done_a - d0, 1);
        check("a_idle_after_ignored_start", busy_a, 0);

        // sensor held high: 16 writes of 1, no rising edge; old count held meanwhile
        w0 = n_wea_a;
        launch(1'b0, 1, 2, ns);
        repeat (20) @(negedge clka);
        check("a_edge_count_held", edge_count_a, 4);
        wait_done(1'b0, 60, at);
        check("a_ones_edge_count", edge_count_a, 0);
        check("a_ram_last", ram_a[15], 1);
        check("a_ones_writes", n_wea_a - w0, 16);

        // divided sampling, pattern 01101101 -> 3 rising edges
        w0 = n_wea_b;
        b0 = n_busy_b;
        launch(1'b1, 2, 6, ns);
        wait_done(1'b1, 120, at);
        check("b_edge_count", edge_count_b, 3);
        repeat (2) @(negedge clka);
        check("b_writes", n_wea_b - w0, 8);
        check("b_busy_cycles_ge_32", (n_busy_b - b0) >= 32, 1);

        // reset held two cycles mid-capture at wr_addr=5
        d0 = n_done_a;
        launch(1'b0, 1, 2, ns);
        repeat (5) @(negedge clka);
        rst = 1'b1;
        repeat (2) @(negedge clka);
        rst = 1'b0;
        check("rst_mid_wea", wea_a, 0);
        check("rst_mid_addra", addra_a, 0);
        check("rst_mid_busy", busy_a, 0);
        check("rst_mid_edge_count_b", edge_count_b, 0);
        repeat (40) @(negedge clka);
        check("rst_mid_no_done", n_done_a - d0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
